// File: rtl/pipe_hzd_pkg.sv
// Shared types and constants for the pipeline hazard unit.
// Forwarding select codes, scoreboard entry layout, select width helper.
package pipe_hzd_pkg;

  localparam int MAX_REG_W = 8;

  localparam int NO_FWD     = 0;
  localparam int FWD_STAGE1 = 1;
  localparam int FWD_STAGE2 = 2;
  localparam int FWD_STAGE3 = 3;

  typedef struct packed {
    logic                 v;
    logic                 wr_en;
    logic [MAX_REG_W-1:0] wr_reg;
    logic                 is_load;
  } hzd_entry_t;

  function automatic int sel_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_hzd_unit_match.sv
// One source operand against every scoreboard stage.
// Youngest matching stage wins; flags a too-young load.
module hzd_match
  import pipe_hzd_pkg::*;
#(
  parameter int REG_W    = 4,
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 1,
  parameter int ZERO_REG = 1,
  parameter int SEL_W    = 2
) (
  input  logic                   rd_en,
  input  logic [REG_W-1:0]       rd_reg,
  input  hzd_entry_t [DEPTH:1]   ents,
  output logic [SEL_W-1:0]       sel,
  output logic                   load_hit
);

  logic zero_blk;

  assign zero_blk = (ZERO_REG != 0) && (rd_reg == '0);

  // Scan oldest to youngest so the youngest match overwrites.
  always_comb begin
    sel      = SEL_W'(NO_FWD);
    load_hit = 1'b0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (rd_en && !zero_blk && ents[k].v && ents[k].wr_en &&
          ents[k].wr_reg == MAX_REG_W'(rd_reg)) begin
        sel      = SEL_W'(k);
        load_hit = ents[k].is_load && (k <= LOAD_LAT);
      end
    end
  end

endmodule

// File: rtl/pipe_hzd_unit.sv
// Hazard, forwarding and load-use stall controller.
// Tracks in-flight destinations for every stage after ID.
module pipe_hzd_unit
  import pipe_hzd_pkg::*;
#(
  parameter int REG_W        = 4,
  parameter int NUM_SRC      = 2,
  parameter int DEPTH        = 3,
  parameter int LOAD_LAT     = 1,
  parameter int FLUSH_STAGES = 1,
  parameter int ZERO_REG     = 1,
  parameter int SEL_W        = sel_width(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     id_valid,
  input  logic [NUM_SRC-1:0]       id_rd_en,
  input  logic [NUM_SRC*REG_W-1:0] id_rd_reg,
  input  logic                     id_wr_en,
  input  logic [REG_W-1:0]         id_wr_reg,
  input  logic                     id_is_load,
  input  logic                     flush,
  input  logic                     hold,
  output logic                     stall,
  output logic                     issue_valid,
  output logic [NUM_SRC*SEL_W-1:0] fwd_sel,
  output logic [15:0]              stall_cnt
);

  localparam int FL_LAST =
    (FLUSH_STAGES < DEPTH) ? FLUSH_STAGES : DEPTH;

  hzd_entry_t [DEPTH:1] sb;
  hzd_entry_t           new_ent;
  logic [NUM_SRC-1:0]   hit;
  logic [15:0]          cnt_q;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    hzd_match #(
      .REG_W    (REG_W),
      .DEPTH    (DEPTH),
      .LOAD_LAT (LOAD_LAT),
      .ZERO_REG (ZERO_REG),
      .SEL_W    (SEL_W)
    ) u_match (
      .rd_en    (id_rd_en[i]),
      .rd_reg   (id_rd_reg[i*REG_W +: REG_W]),
      .ents     (sb),
      .sel      (fwd_sel[i*SEL_W +: SEL_W]),
      .load_hit (hit[i])
    );
  end

  assign stall       = id_valid & ~hold & ~flush & (|hit);
  assign issue_valid = id_valid & ~stall & ~flush & ~hold;
  assign stall_cnt   = cnt_q;

  // Entry for the instruction leaving ID this cycle.
  always_comb begin
    new_ent         = '0;
    new_ent.v       = 1'b1;
    new_ent.wr_en   = id_wr_en;
    new_ent.wr_reg  = MAX_REG_W'(id_wr_reg);
    new_ent.is_load = id_is_load;
  end

  // Advance the scoreboard, kill flushed stages, count stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb    <= '0;
      cnt_q <= '0;
    end else if (!hold) begin
      for (int k = DEPTH; k >= 2; k--) begin
        sb[k] <= sb[k-1];
      end
      sb[1] <= issue_valid ? new_ent : '0;
      if (flush) begin
        for (int k = 2; k <= FL_LAST; k++) begin
          sb[k].v <= 1'b0;
        end
      end
      if (stall && cnt_q != 16'hFFFF) begin
        cnt_q <= cnt_q + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_hzd_unit.sv
// Directed bench for pipe_hzd_unit with default parameters.
// Hand-computed expectations checked by immediate assertions.
module tb_pipe_hzd_unit;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic [1:0]  id_rd_en;
  logic [7:0]  id_rd_reg;
  logic        id_wr_en;
  logic [3:0]  id_wr_reg;
  logic        id_is_load;
  logic        flush;
  logic        hold;
  logic        stall;
  logic        issue_valid;
  logic [3:0]  fwd_sel;
  logic [15:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  pipe_hzd_unit dut (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .id_rd_en    (id_rd_en),
    .id_rd_reg   (id_rd_reg),
    .id_wr_en    (id_wr_en),
    .id_wr_reg   (id_wr_reg),
    .id_is_load  (id_is_load),
    .flush       (flush),
    .hold        (hold),
    .stall       (stall),
    .issue_valid (issue_valid),
    .fwd_sel     (fwd_sel),
    .stall_cnt   (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic id(input logic v, input logic [1:0] en,
                    input logic [3:0] r0, input logic [3:0] r1,
                    input logic we, input logic [3:0] wd,
                    input logic ld);
    id_valid   = v;
    id_rd_en   = en;
    id_rd_reg  = {r1, r0};
    id_wr_en   = we;
    id_wr_reg  = wd;
    id_is_load = ld;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst   = 1'b1;
    flush = 1'b0;
    hold  = 1'b0;
    id(1'b0, 2'b00, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0);
    #2;
    chk("rst_stall", {15'd0, stall}, 16'd0);
    chk("rst_issue", {15'd0, issue_valid}, 16'd0);
    chk("rst_fwd", {12'd0, fwd_sel}, 16'd0);
    chk("rst_cnt", stall_cnt, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    next();

    // ADD r3 then a reader of r3
    id(1'b1, 2'b11, 4'd1, 4'd2, 1'b1, 4'd3, 1'b0);
    @(negedge clk);
    chk("add_issue", {15'd0, issue_valid}, 16'd1);
    chk("add_fwd", {12'd0, fwd_sel}, 16'd0);
    next();
    id(1'b1, 2'b01, 4'd3, 4'd0, 1'b1, 4'd7, 1'b0);
    @(negedge clk);
    chk("raw_fwd", {12'd0, fwd_sel}, 16'h1);
    chk("raw_stall", {15'd0, stall}, 16'd0);
    chk("raw_issue", {15'd0, issue_valid}, 16'd1);
    next();

    // LW r5 then reader on source 1
    id(1'b1, 2'b00, 4'd0, 4'd0, 1'b1, 4'd5, 1'b1);
    next();
    id(1'b1, 2'b10, 4'd0, 4'd5, 1'b1, 4'd8, 1'b0);
    @(negedge clk);
    chk("lu_stall", {15'd0, stall}, 16'd1);
    chk("lu_issue", {15'd0, issue_valid}, 16'd0);
    chk("lu_fwd", {12'd0, fwd_sel}, 16'h4);
    next();
    @(negedge clk);
    chk("lu2_stall", {15'd0, stall}, 16'd0);
    chk("lu2_issue", {15'd0, issue_valid}, 16'd1);
    chk("lu2_fwd", {12'd0, fwd_sel}, 16'h8);
    chk("lu2_cnt", stall_cnt, 16'd1);
    next();

    // two writers of r2, reader of r2 on both sources
    id(1'b1, 2'b00, 4'd0, 4'd0, 1'b1, 4'd2, 1'b0);
    next();
    next();
    id(1'b1, 2'b11, 4'd2, 4'd2, 1'b1, 4'd0, 1'b0);
    @(negedge clk);
    chk("r2_both", {12'd0, fwd_sel}, 16'h5);
    next();
    id(1'b1, 2'b11, 4'd0, 4'd0, 1'b1, 4'd0, 1'b0);
    @(negedge clk);
    chk("zero_reg", {12'd0, fwd_sel}, 16'h0);
    next();
    id(1'b1, 2'b11, 4'd0, 4'd2, 1'b0, 4'd0, 1'b0);
    @(negedge clk);
    chk("zero_old", {12'd0, fwd_sel}, 16'hC);
    next();

    // flush with LW r4 in stage 1 and its reader in ID
    id(1'b1, 2'b00, 4'd0, 4'd0, 1'b1, 4'd4, 1'b1);
    next();
    id(1'b1, 2'b01, 4'd4, 4'd0, 1'b1, 4'd6, 1'b0);
    flush = 1'b1;
    @(negedge clk);
    chk("fl_stall", {15'd0, stall}, 16'd0);
    chk("fl_issue", {15'd0, issue_valid}, 16'd0);
    chk("fl_fwd", {12'd0, fwd_sel}, 16'h1);
    next();
    flush = 1'b0;
    id(1'b1, 2'b11, 4'd4, 4'd6, 1'b0, 4'd0, 1'b0);
    @(negedge clk);
    chk("fl_kill", {12'd0, fwd_sel}, 16'h2);
    chk("fl_nostall", {15'd0, stall}, 16'd0);
    next();
    @(negedge clk);
    chk("fl_wb", {12'd0, fwd_sel}, 16'h3);
    next();

    // hold freezes with a pending load-use
    id(1'b1, 2'b00, 4'd0, 4'd0, 1'b1, 4'd5, 1'b1);
    next();
    id(1'b1, 2'b01, 4'd5, 4'd0, 1'b0, 4'd0, 1'b0);
    hold = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("hold_stall", {15'd0, stall}, 16'd0);
      chk("hold_issue", {15'd0, issue_valid}, 16'd0);
      chk("hold_fwd", {12'd0, fwd_sel}, 16'h1);
      chk("hold_cnt", stall_cnt, 16'd1);
      next();
    end
    hold = 1'b0;
    @(negedge clk);
    chk("unhold_stall", {15'd0, stall}, 16'd1);
    next();
    @(negedge clk);
    chk("unhold_cnt", stall_cnt, 16'd2);
    chk("unhold_fwd", {12'd0, fwd_sel}, 16'h2);
    next();

    // asynchronous reset in the middle of a stall
    id(1'b1, 2'b00, 4'd0, 4'd0, 1'b1, 4'd5, 1'b1);
    next();
    id(1'b1, 2'b01, 4'd5, 4'd0, 1'b0, 4'd0, 1'b0);
    @(negedge clk);
    chk("pre_rst_stall", {15'd0, stall}, 16'd1);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_stall", {15'd0, stall}, 16'd0);
    chk("mid_rst_fwd", {12'd0, fwd_sel}, 16'h0);
    chk("mid_rst_cnt", stall_cnt, 16'd0);
    #1 rst = 1'b0;
    #1;
    chk("post_rst_fwd", {12'd0, fwd_sel}, 16'h0);
    chk("post_rst_issue", {15'd0, issue_valid}, 16'd1);
    next();

    // saturation of the stall counter
    id(1'b1, 2'b00, 4'd0, 4'd0, 1'b1, 4'd5, 1'b1);
    next();
    id(1'b1, 2'b01, 4'd5, 4'd0, 1'b0, 4'd0, 1'b0);
    @(negedge clk);
    chk("sat_stall", {15'd0, stall}, 16'd1);
    force dut.cnt_q = 16'hFFFF;
    #1;
    release dut.cnt_q;
    #1;
    chk("sat_preset", stall_cnt, 16'hFFFF);
    next();
    @(negedge clk);
    chk("sat_hold", stall_cnt, 16'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
